bcd_bottle_counter: RTL

Two-digit BCD bottle counter for the wine line. It synchronises and filters the bottle-presence sensor, counts each bottle on the sensor's rising edge, and groups bottles into boxes. It outputs the unit digit, the tens digit and a box-count digit as 4-bit BCD nibbles. Each nibble drives one `displaydecimal` instance directly, with bit 3 on decoder input A (MSB) and bit 0 on input D.

---
 rtl/bcd_bottle_counter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_bottle_counter.sv
// -----------------------------------------------------------------------------
// bcd_bottle_counter
//   Two-digit BCD bottle counter for the wine line. It synchronises and
//   filters the bottle-presence sensor, counts each rising edge of the
//   filtered level, and groups bottles into boxes of BOX_SIZE. It drives
//   unit, tens and box-count BCD nibbles that feed displaydecimal decoders
//   directly (bit 3 -> decoder input A, bit 0 -> decoder input D).
//
//   Compile-time option:
//     BOTTLE_DEBOUNCE_EN  defined   -> run-length filter of DEB_CYCLES samples
//                         undefined -> filtered level is the synchronised level
//
//   Parameters:
//     DEB_CYCLES  1..15  identical samples needed to change the filtered level
//     BOX_SIZE    1..15  bottles per box
//     WRAP        1 = 99 wraps to 00 with CARRY, 0 = saturate at 99
// -----------------------------------------------------------------------------
module bcd_bottle_counter #(
    parameter int DEB_CYCLES = 4,
    parameter int BOX_SIZE   = 6,
    parameter int WRAP       = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SENSOR,
    input  logic       EN,
    input  logic       CLR,
    output logic [3:0] UNI,
    output logic [3:0] DEZ,
    output logic [3:0] BOXCNT,
    output logic       FULL,
    output logic       CARRY,
    output logic       BOX
);

    // Last legal value of the box progress counter before a box completes.
    localparam logic [3:0] BOX_LAST = 4'(BOX_SIZE - 1);
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // BCD digit increment, 9 rolls over to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Input path: synchroniser
    // -------------------------------------------------------------------------
    logic s1_q;
    logic s2_q;

    // Two-flop synchroniser bringing the asynchronous sensor into CLK domain.
    always_ff @(posedge CLK) begin
        // NOTE: the reset is synchronous: RST_N is tested inside the clocked
        // block and is deliberately absent from the sensitivity list.
        if (!RST_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make s2_q take the previous s1_q;
            // blocking ones would collapse the two stages into a single flop.
            s1_q <= SENSOR;
            s2_q <= s1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Input path: filter
    // -------------------------------------------------------------------------
    logic filt;

`ifdef BOTTLE_DEBOUNCE_EN
    // The filtered level flips on the DEB_CYCLES-th consecutive differing
    // sample, so the comparison is against DEB_CYCLES-1 before incrementing.
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    logic [3:0] run_q;
    logic [3:0] run_d;
    logic       filt_q;
    logic       filt_d;

    // Run-length filter: count differing samples, clear on any agreeing one.
    always_comb begin
        run_d  = 4'd0;
        filt_d = filt_q;
        if (s2_q != filt_q) begin
            if (run_q >= DEB_LAST) begin
                filt_d = s2_q;
                run_d  = 4'd0;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    // Filter state register; CLR deliberately has no effect here.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            run_q  <= 4'd0;
            filt_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    // Without the filter any synchronised high of one cycle is a bottle.
    assign filt = s2_q;
`endif

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    logic prev_q;
    logic edge_evt;

    // Previous filtered level; a rising edge is filt high with prev low.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filt;
        end
    end

    assign edge_evt = filt & ~prev_q;

    // -------------------------------------------------------------------------
    // Counter, box tracking and pulses
    // -------------------------------------------------------------------------
    logic [3:0] uni_q,    uni_d;
    logic [3:0] dez_q,    dez_d;
    logic [3:0] boxcnt_q, boxcnt_d;
    logic [3:0] prog_q,   prog_d;
    logic       carry_q,  carry_d;
    logic       box_q,    box_d;

    logic at_max;
    logic saturated;
    logic step;

    assign at_max    = (uni_q == BCD_MAX) && (dez_q == BCD_MAX);
    assign saturated = (WRAP == 0) && at_max;
    // A saturated counter ignores the edge entirely, including box progress.
    assign step      = edge_evt && EN && !saturated;

    // Next-state for digits, box progress and the one-cycle pulses.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        uni_d    = uni_q;
        dez_d    = dez_q;
        boxcnt_d = boxcnt_q;
        prog_d   = prog_q;
        carry_d  = 1'b0;
        box_d    = 1'b0;

        if (CLR) begin
            // Clear wins over a coincident edge, which is simply lost.
            uni_d    = 4'd0;
            dez_d    = 4'd0;
            boxcnt_d = 4'd0;
            prog_d   = 4'd0;
        end else if (step) begin
            if (at_max) begin
                // Only reachable with WRAP=1; saturation blocks step otherwise.
                uni_d   = 4'd0;
                dez_d   = 4'd0;
                carry_d = 1'b1;
            end else if (uni_q >= BCD_MAX) begin
                uni_d = 4'd0;
                dez_d = bcd_inc(dez_q);
            end else begin
                uni_d = uni_q + 4'd1;
            end

            if (prog_q >= BOX_LAST) begin
                prog_d   = 4'd0;
                box_d    = 1'b1;
                boxcnt_d = bcd_inc(boxcnt_q);
            end else begin
                prog_d = prog_q + 4'd1;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            uni_q    <= 4'd0;
            dez_q    <= 4'd0;
            boxcnt_q <= 4'd0;
            prog_q   <= 4'd0;
            carry_q  <= 1'b0;
            box_q    <= 1'b0;
        end else begin
            uni_q    <= uni_d;
            dez_q    <= dez_d;
            boxcnt_q <= boxcnt_d;
            prog_q   <= prog_d;
            carry_q  <= carry_d;
            box_q    <= box_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign UNI    = uni_q;
    assign DEZ    = dez_q;
    assign BOXCNT = boxcnt_q;
    assign FULL   = at_max;
    assign CARRY  = carry_q;
    assign BOX    = box_q;

endmodule
